// File: rtl/shift_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_scheduler_pkg
// Description : Shared definitions for the shift scheduler: data width,
//               opcode encodings, FSM state encoding and opcode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_scheduler_pkg;

    // Data path width and the number of bits needed to express a shift amount
    localparam int DATA_W = 32;
    localparam int SH_W   = $clog2(DATA_W);

    // Operation codes
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Rotates are the opcodes with the upper bit set
    function automatic logic op_is_rotate(input logic [1:0] op);
        return op[1];
    endfunction

    // SLL and ROL move bits toward the MSB on the first pass
    function automatic logic op_is_left(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_scheduler_shift32.sv
`default_nettype none
// ============================================================================
// Module      : shift_scheduler_shift32
// Description : Combinational logical shifter. Shifts d left (lnr=1) or
//               right (lnr=0) by the full-width amount s; any amount of
//               DATA_W or more yields zero.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_scheduler_shift32
    import shift_scheduler_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] s,
    input  logic              lnr,
    output logic [DATA_W-1:0] y
);

    logic w_overflow;

    // Any set bit above the in-range field means the shift clears every bit
    assign w_overflow = |s[DATA_W-1:SH_W];

    // Logical shift in the requested direction
    always_comb begin
        y = '0;
        if (!w_overflow) begin
            y = lnr ? (d << s[SH_W-1:0]) : (d >> s[SH_W-1:0]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : shift_scheduler
// Description : Two-requester round-robin scheduler sharing one logical
//               shifter. Rotates take two passes (shift, then opposite shift
//               by DATA_W-k ORed in); logical shifts take one.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_scheduler
    import shift_scheduler_pkg::*;
#(
    parameter logic RR_START = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] s0,
    input  logic [DATA_W-1:0] s1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] y,
    output logic              busy
);

    localparam logic [DATA_W-1:0] C_WIDTH = DATA_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_favour;
    logic              r_grant;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_y_hold;

    logic              w_start;
    logic              w_pick;
    logic              w_rot;
    logic [DATA_W-1:0] w_k;
    logic [DATA_W-1:0] w_sh_s;
    logic              w_sh_lnr;
    logic [DATA_W-1:0] w_sh_y;

    // A lone requester wins outright; a tie goes to the favoured side
    assign w_start = req0 | req1;
    assign w_pick  = (req0 & req1) ? r_favour : req1;

    // Rotates only use the low bits of the amount
    assign w_rot = op_is_rotate(r_op);
    assign w_k   = {{(DATA_W-SH_W){1'b0}}, r_s[SH_W-1:0]};

    shift_scheduler_shift32 u_shift32 (
        .d   (r_d),
        .s   (w_sh_s),
        .lnr (w_sh_lnr),
        .y   (w_sh_y)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, shifter control and completion pulses
    always_comb begin
        w_state_nxt = r_state;
        w_sh_s      = r_s;
        w_sh_lnr    = op_is_left(r_op);
        ack0        = 1'b0;
        ack1        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_PASS1;
            end
            ST_PASS1: begin
                if (w_rot) w_sh_s = w_k;
                w_state_nxt = (w_rot && (w_k != '0)) ? ST_PASS2 : ST_DONE;
            end
            ST_PASS2: begin
                // Bits that wrapped around come back from the other end
                w_sh_s      = C_WIDTH - w_k;
                w_sh_lnr    = ~op_is_left(r_op);
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ack0        = ~r_grant;
                ack1        = r_grant;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result is live from the accumulator during DONE, then held
    assign y    = (r_state == ST_DONE) ? r_acc : r_y_hold;
    assign busy = (r_state != ST_IDLE);

    // Grant latch, accumulator, result hold and round-robin favour
    always_ff @(posedge clk) begin
        if (rst) begin
            r_favour <= RR_START;
            r_grant  <= 1'b0;
            r_op     <= OP_SLL;
            r_d      <= '0;
            r_s      <= '0;
            r_acc    <= '0;
            r_y_hold <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_grant <= w_pick;
                        r_op    <= w_pick ? op1 : op0;
                        r_d     <= w_pick ? d1  : d0;
                        r_s     <= w_pick ? s1  : s0;
                    end
                end
                ST_PASS1: r_acc <= w_sh_y;
                ST_PASS2: r_acc <= r_acc | w_sh_y;
                ST_DONE: begin
                    r_y_hold <= r_acc;
                    r_favour <= ~r_grant;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_scheduler
// Description : Self-checking bench for shift_scheduler: directed cases,
//               tie arbitration, reset abort and randomized single requests
//               compared against a behavioural shift/rotate model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_scheduler;
    import shift_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [31:0] d0, d1, s0, s1;
    logic        ack0, ack1, busy;
    logic [31:0] y;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_y;

    always #5 clk = ~clk;

    shift_scheduler #(.RR_START(1'b0)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .op0  (op0),
        .op1  (op1),
        .d0   (d0),
        .d1   (d1),
        .s0   (s0),
        .s1   (s1),
        .ack0 (ack0),
        .ack1 (ack1),
        .y    (y),
        .busy (busy)
    );

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result from the operation definitions
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s);
        logic [63:0] dd;
        int          k;
        dd = {d, d};
        k  = int'(s % 32);
        case (op)
            2'b00:   return (s >= 32) ? 32'h0 : (d << s);
            2'b01:   return (s >= 32) ? 32'h0 : (d >> s);
            2'b10:   begin dd = dd << k; return dd[63:32]; end
            default: begin dd = dd >> k; return dd[31:0];  end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] s);
        return (op[1] && (s % 32) != 0) ? 3 : 2;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        prev_y = 32'h0;
    endtask

    // Issue one request on an idle DUT; entered and left just after a posedge
    task automatic run_op(input bit who, input logic [1:0] op, input logic [31:0] d,
                          input logic [31:0] s, input string tag);
        logic [31:0] expy;
        int          explat;
        bit          got;
        expy   = model(op, d, s);
        explat = model_lat(op, s);
        if (who) begin req1 = 1'b1; op1 = op; d1 = d; s1 = s; end
        else     begin req0 = 1'b1; op0 = op; d0 = d; s0 = s; end
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({tag, "_idle_ack"}, 32'({ack1, ack0}), 32'h0);
                check({tag, "_held_y"}, y, prev_y);
            end
            if (c == 1) begin
                check({tag, "_busy"}, 32'(busy), 32'h1);
                // Operand changes after the grant must not matter
                if (who) begin op1 = 2'($urandom); d1 = $urandom; s1 = $urandom; end
                else     begin op0 = 2'($urandom); d0 = $urandom; s0 = $urandom; end
            end
            if (ack0 | ack1) begin
                got = 1'b1;
                check({tag, "_ack_id"}, 32'({ack1, ack0}), who ? 32'h2 : 32'h1);
                check({tag, "_y"}, y, expy);
                check({tag, "_lat"}, 32'(c), 32'(explat));
                req0 = 1'b0;
                req1 = 1'b0;
                prev_y = expy;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    // Both requesters held: grants must alternate starting with requester 0
    task automatic tie_test();
        logic [31:0] exp0, exp1;
        int          n_ack;
        exp0 = model(OP_ROL, 32'hdeadbeef, 32'd4);
        exp1 = model(OP_SRL, 32'h80000001, 32'd3);
        req0 = 1'b1; op0 = OP_ROL; d0 = 32'hdeadbeef; s0 = 32'd4;
        req1 = 1'b1; op1 = OP_SRL; d1 = 32'h80000001; s1 = 32'd3;
        n_ack = 0;
        for (int c = 0; c < 30 && n_ack < 3; c++) begin
            @(negedge clk);
            check("tie_both", 32'(ack0 & ack1), 32'h0);
            if (ack0 | ack1) begin
                check("tie_order", 32'({ack1, ack0}), (n_ack == 1) ? 32'h2 : 32'h1);
                check("tie_y", y, ack1 ? exp1 : exp0);
                prev_y = ack1 ? exp1 : exp0;
                n_ack++;
                if (n_ack == 3) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        if (n_ack != 3) check("tie_timeout", 32'(n_ack), 32'd3);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reset during PASS2 of a rotate aborts it; the held request then reruns
    task automatic reset_abort_test();
        bit got;
        req1 = 1'b1; op1 = OP_ROR; d1 = 32'h12345678; s1 = 32'd8;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pass2", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ack", 32'({ack1, ack0}), 32'h0);
        check("abort_y", y, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        prev_y = 32'h0;
        got = 1'b0;
        for (int c = 1; c < 8 && !got; c++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                got = 1'b1;
                check("rerun_ack_id", 32'({ack1, ack0}), 32'h2);
                check("rerun_y", y, 32'h78123456);
                check("rerun_lat", 32'(c), 32'd3);
                req1 = 1'b0;
                prev_y = 32'h78123456;
            end
        end
        if (!got) check("rerun_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        d0 = 32'h0; d1 = 32'h0; s0 = 32'h0; s1 = 32'h0;
        prev_y = 32'h0;
        do_reset();

        @(negedge clk);
        check("rst_ack", 32'({ack1, ack0}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_y", y, 32'h0);
        @(posedge clk);
        #1;

        run_op(1'b0, OP_SLL, 32'ha5a5a5a5, 32'd4,  "sll");
        run_op(1'b1, OP_ROR, 32'h12345678, 32'd8,  "ror8");
        run_op(1'b1, OP_ROL, 32'h12345678, 32'd4,  "rol4");
        run_op(1'b0, OP_SRL, 32'hffffffff, 32'd33, "srl33");
        run_op(1'b0, OP_ROL, 32'h12345678, 32'd32, "rol32");
        run_op(1'b1, OP_SLL, 32'h0000ffff, 32'd31, "sll31");

        reset_abort_test();

        do_reset();
        tie_test();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            run_op(1'($urandom), 2'($urandom), $urandom, rs, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the design never settles
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
